// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op encoding, FSM states and
// op-class helpers.
package muldiv_pkg;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} md_state_t;

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == MULH) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Start/busy/done handshake and operand/result bus between the execute stage and muldiv_ctrl.
interface muldiv_ctrl_if #(
  parameter int unsigned DWIDTH = 32
);
  logic              MD_Start;
  logic [2:0]        MD_OP;
  logic [DWIDTH-1:0] MD_In_A;
  logic [DWIDTH-1:0] MD_In_B;
  logic              MD_Kill;
  logic              MD_Busy;
  logic              MD_Done;
  logic [DWIDTH-1:0] MD_Out;

  modport master (
    output MD_Start, MD_OP, MD_In_A, MD_In_B, MD_Kill,
    input  MD_Busy, MD_Done, MD_Out
  );

  modport slave (
    input  MD_Start, MD_OP, MD_In_A, MD_In_B, MD_Kill,
    output MD_Busy, MD_Done, MD_Out
  );
endinterface

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign correction.
module md_sign_fix #(
  parameter int unsigned Width = 32
) (
  input  logic             neg,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  assign dout = neg ? (~din + {{(Width-1){1'b0}}, 1'b1}) : din;

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer (shift-add multiply, restoring divide).
// Optional single-cycle multiplier path enabled by defining MULDIV_FAST_MUL_EN.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input logic          Clk,
  input logic          Rst,
  muldiv_ctrl_if.slave md
);

  localparam int unsigned CntW = $clog2(DWIDTH);
  localparam logic [DWIDTH-1:0] MinNeg = {1'b1, {(DWIDTH-1){1'b0}}};

  md_state_t           state_q, state_d;
  logic [CntW-1:0]     cnt_q;
  logic [2:0]          op_q;
  logic [DWIDTH-1:0]   mcand_q;  // multiplicand or divisor magnitude
  logic [2*DWIDTH-1:0] acc_q;    // {hi, lo}: product, or {remainder, quotient}
  logic                neg_res_q, neg_rem_q;
  logic [DWIDTH-1:0]   res_q, out_q, out_d;
  logic                busy_q, busy_d, done_q, done_d;

  logic                neg_a, neg_b, start_div, div_zero, div_ovf, special, accept;
  logic [DWIDTH-1:0]   mag_a, mag_b, spec_res;
  logic [2*DWIDTH-1:0] fast_prod;

  assign neg_a     = is_signed_a(md.MD_OP) & md.MD_In_A[DWIDTH-1];
  assign neg_b     = is_signed_b(md.MD_OP) & md.MD_In_B[DWIDTH-1];
  assign start_div = is_div(md.MD_OP);
  assign div_zero  = (md.MD_In_B == '0);
  assign div_ovf   = is_signed_b(md.MD_OP) & (md.MD_In_A == MinNeg) & (&md.MD_In_B);
  assign special   = start_div & (div_zero | div_ovf);
  assign accept    = (state_q == StIdle) & md.MD_Start & ~md.MD_Kill;
  // op[1] distinguishes REM/REMU from DIV/DIVU
  assign spec_res  = md.MD_OP[1] ? (div_zero ? md.MD_In_A : '0)
                                 : (div_zero ? '1 : md.MD_In_A);

  md_sign_fix #(.Width(DWIDTH)) u_mag_a (.neg(neg_a), .din(md.MD_In_A), .dout(mag_a));
  md_sign_fix #(.Width(DWIDTH)) u_mag_b (.neg(neg_b), .din(md.MD_In_B), .dout(mag_b));

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
  assign fast_prod = {{DWIDTH{1'b0}}, mag_a} * {{DWIDTH{1'b0}}, mag_b};
`else
  localparam bit FastMul = 1'b0;
  assign fast_prod = '0;
`endif

  // One iteration step for each algorithm
  logic [DWIDTH:0]     mul_sum, rem_sh, trial;
  logic [2*DWIDTH-1:0] mul_next, div_next;
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*DWIDTH-1:DWIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, acc_q[DWIDTH-1:1]};
    rem_sh   = {acc_q[2*DWIDTH-1:DWIDTH], acc_q[DWIDTH-1]};
    trial    = rem_sh - {1'b0, mcand_q};
    div_next = trial[DWIDTH] ? {rem_sh[DWIDTH-1:0], acc_q[DWIDTH-2:0], 1'b0}
                             : {trial[DWIDTH-1:0], acc_q[DWIDTH-2:0], 1'b1};
  end

  // Sign correction and result selection
  logic                fix_neg;
  logic [2*DWIDTH-1:0] fix_in, fix_out;
  logic [DWIDTH-1:0]   fix_res;
  always_comb begin
    if (is_div(op_q)) begin
      fix_in  = {{DWIDTH{1'b0}}, op_q[1] ? acc_q[2*DWIDTH-1:DWIDTH] : acc_q[DWIDTH-1:0]};
      fix_neg = op_q[1] ? neg_rem_q : neg_res_q;
    end else begin
      fix_in  = acc_q;
      fix_neg = neg_res_q;
    end
  end

  md_sign_fix #(.Width(2*DWIDTH)) u_fix_res (.neg(fix_neg), .din(fix_in), .dout(fix_out));

  assign fix_res = (is_div(op_q) || op_q[1:0] == 2'b00) ? fix_out[DWIDTH-1:0]
                                                         : fix_out[2*DWIDTH-1:DWIDTH];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) begin
        if (special)                 state_d = StDone;
        else if (FastMul && !start_div) state_d = StFix;
        else                         state_d = StCalc;
      end
      StCalc: if (md.MD_Kill) state_d = StIdle;
              else if (cnt_q == '0) state_d = StFix;
      StFix:  state_d = md.MD_Kill ? StIdle : StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    done_d = (state_q == StDone);
    busy_d = (state_d != StIdle) | done_d;
    out_d  = done_d ? res_q : out_q;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_q     <= '0;
      op_q      <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_q     <= '0;
      out_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      out_q  <= out_d;
      case (state_q)
        StIdle: if (accept) begin
          op_q      <= md.MD_OP;
          neg_res_q <= neg_a ^ neg_b;
          neg_rem_q <= neg_a;
          cnt_q     <= CntW'(DWIDTH - 1);
          mcand_q   <= start_div ? mag_b : mag_a;
          acc_q     <= (FastMul && !start_div) ? fast_prod
                                               : {{DWIDTH{1'b0}}, start_div ? mag_a : mag_b};
          if (special) res_q <= spec_res;
        end
        StCalc: begin
          acc_q <= is_div(op_q) ? div_next : mul_next;
          if (cnt_q != '0) cnt_q <= cnt_q - CntW'(1);
        end
        StFix:   res_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign md.MD_Busy = busy_q;
  assign md.MD_Done = done_q;
  assign md.MD_Out  = out_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed and randomized checks of muldiv_ctrl against a plain-arithmetic RV32M model.
module tb_muldiv_ctrl;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  logic [31:0] last_exp = '0;

  muldiv_ctrl_if #(.DWIDTH(32)) md ();
  muldiv_ctrl #(.DWIDTH(32)) dut (.Clk(Clk), .Rst(Rst), .md(md));

  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no end of test, required end before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb, ua, ub;
    int ia, ib;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    ia = a;
    ib = b;
    p  = '0;
    case (op)
      OP_MUL:    begin p = sa * sb; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 2;
`endif
    return 34;
  endfunction

  // Called at a negedge with the DUT idle (or in its done cycle); returns in the done cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag, input int inject_k);
    int k;
    bit busy_bad;
    busy_bad = 1'b0;
    md.MD_Start = 1'b1;
    md.MD_OP    = op;
    md.MD_In_A  = a;
    md.MD_In_B  = b;
    @(posedge Clk);
    k = 0;
    while (k < 60) begin
      @(negedge Clk);
      md.MD_Start = 1'b0;
      if (k == inject_k) begin
        md.MD_Start = 1'b1;
        md.MD_OP    = OP_MUL;
        md.MD_In_A  = $urandom;
        md.MD_In_B  = $urandom;
      end
      if (md.MD_Busy !== 1'b1) busy_bad = 1'b1;
      if (md.MD_Done === 1'b1) break;
      @(posedge Clk);
      k++;
    end
    md.MD_Start = 1'b0;
    check({tag, "_latency"}, k, ref_lat(op, a, b));
    check({tag, "_result"}, md.MD_Out, exp);
    check({tag, "_busy"}, {31'b0, busy_bad}, 32'd0);
    last_exp = exp;
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    bit          seen;
    md.MD_Start = 1'b0;
    md.MD_OP    = '0;
    md.MD_In_A  = '0;
    md.MD_In_B  = '0;
    md.MD_Kill  = 1'b0;
    #2 Rst = 1'b1;
    #1;
    check("reset_busy", {31'b0, md.MD_Busy}, 32'd0);
    check("reset_done", {31'b0, md.MD_Done}, 32'd0);
    check("reset_out", md.MD_Out, 32'd0);
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);

    // Directed cases, issued back to back
    run_op(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_neg", -1);
    run_op(OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulh_min", -1);
    run_op(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max", -1);
    run_op(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_max", -1);
    run_op(OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div_neg", -1);
    run_op(OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem_neg", -1);
    run_op(OP_DIVU,   32'd100,        32'd7,         32'd14,        "divu", -1);
    run_op(OP_REMU,   32'd100,        32'd7,         32'd2,         "remu", -1);
    run_op(OP_DIV,    32'd7,          32'd0,         32'hFFFF_FFFF, "div_zero", -1);
    run_op(OP_REM,    32'd7,          32'd0,         32'd7,         "rem_zero", -1);
    run_op(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf", -1);
    run_op(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "rem_ovf", -1);
    @(negedge Clk);
    check("done_pulse", {31'b0, md.MD_Done}, 32'd0);
    check("idle_busy", {31'b0, md.MD_Busy}, 32'd0);

    // Start pulse mid-operation must be ignored
    run_op(OP_DIV, 32'd1000, 32'd7, 32'd142, "start_ignored", 5);
    @(negedge Clk);

    // Kill at cycle 10 of a divide, then kill together with start in idle
    md.MD_Start = 1'b1;
    md.MD_OP    = OP_DIVU;
    md.MD_In_A  = 32'h1234_5678;
    md.MD_In_B  = 32'd3;
    @(posedge Clk);
    @(negedge Clk);
    md.MD_Start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge Clk);
      @(negedge Clk);
    end
    md.MD_Kill = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    md.MD_Kill = 1'b0;
    check("kill_busy", {31'b0, md.MD_Busy}, 32'd0);
    check("kill_out_held", md.MD_Out, last_exp);
    md.MD_Start = 1'b1;
    md.MD_Kill  = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    md.MD_Start = 1'b0;
    md.MD_Kill  = 1'b0;
    check("kill_start_busy", {31'b0, md.MD_Busy}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (md.MD_Done === 1'b1 || md.MD_Busy === 1'b1) seen = 1'b1;
    end
    check("kill_no_done", {31'b0, seen}, 32'd0);
    check("kill_out_final", md.MD_Out, last_exp);

    // Randomized operations against the model
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(op, a, b, ref_md(op, a, b), $sformatf("rand%0d_op%0d", n, op), -1);
    end
    @(negedge Clk);

    // Asynchronous reset in the middle of an iterative divide
    md.MD_Start = 1'b1;
    md.MD_OP    = OP_DIV;
    md.MD_In_A  = 32'd1000;
    md.MD_In_B  = 32'd7;
    @(posedge Clk);
    @(negedge Clk);
    md.MD_Start = 1'b0;
    repeat (10) @(negedge Clk);
    Rst = 1'b1;
    #1;
    check("rst_mid_busy", {31'b0, md.MD_Busy}, 32'd0);
    check("rst_mid_done", {31'b0, md.MD_Done}, 32'd0);
    check("rst_mid_out", md.MD_Out, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    check("rst_after_busy", {31'b0, md.MD_Busy}, 32'd0);
    run_op(OP_MUL, 32'd3, 32'd4, 32'd12, "mul_after_rst", -1);
    @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
